// File: rtl/mips_bus_ram_wait.sv
// rtl/mips_bus_ram_wait.sv - Avalon-style word RAM slave with generated wait states and sticky error flag
module mips_bus_ram_wait #(
    parameter              RAM_INIT_FILE = "",
    parameter int          DEPTH_WORDS   = 2048,
    parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
    parameter int          WAIT_MODE     = 0,
    parameter int          MAX_WAIT      = 0,
    parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic        write,
    input  logic        read,
    output logic        waitrequest,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        err
);

    localparam int          IW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) * 33'd4;
    // An all-zero Galois LFSR never leaves zero, so force a nonzero start.
    localparam logic [7:0]  SEED_EFF = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] WAITING = 1'b1;

    logic [0:0]  state;
    logic [3:0]  cnt;
    logic [7:0]  lfsr;
    logic [7:0]  lfsr_next;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic        rd_q;
    logic        wr_q;

    logic [31:0] mem [DEPTH_WORDS];

    // Zero-filled at time 0; contents survive rst.
    initial begin
        for (int m = 0; m < DEPTH_WORDS; m++) mem[m] = 32'h0;
    end

    logic        req;
    logic        in_wait;
    logic [3:0]  w_rand;
    logic [3:0]  w;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_be;
    logic        e_rd;
    logic        e_wr;
    logic [31:0] off;
    logic        valid;
    logic [IW-1:0] idx;
    logic        done;
    logic        abort;
    logic        addr_chg;
    logic        do_write;

    // Request decode, wait-count selection and effective transfer fields.
    // While WAITING, the latched request is authoritative, not the live bus.
    always_comb begin
        req       = read | write;
        in_wait   = (state == WAITING);
        lfsr_next = {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);
        w_rand    = 4'(lfsr % 8'(MAX_WAIT + 1));
        w         = (WAIT_MODE == 1) ? w_rand : 4'(MAX_WAIT);
        e_addr    = in_wait ? addr_q  : address;
        e_wdata   = in_wait ? wdata_q : writedata;
        e_be      = in_wait ? be_q    : byteenable;
        e_rd      = in_wait ? rd_q    : read;
        e_wr      = in_wait ? wr_q    : write;
        off       = e_addr - BASE_ADDR;
        valid     = (e_addr[1:0] == 2'b00) && ({1'b0, off} < SPAN);
        idx       = off[IW+1:2];
        done      = !rst && req && (in_wait ? (cnt == 4'd0) : (w == 4'd0));
        abort     = in_wait && !req;
        addr_chg  = in_wait && req && (address != addr_q);
        do_write  = done && valid && e_wr && !e_rd;
        waitrequest = !rst && (in_wait ? (cnt != 4'd0) : (req && (w != 4'd0)));
        readdata  = (done && e_rd && valid) ? mem[idx] : 32'h0;
    end

    // Transfer FSM, LFSR advance on each accepted request, sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            lfsr    <= SEED_EFF;
            err     <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            be_q    <= 4'h0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            if (state == IDLE) begin
                if (req) begin
                    lfsr <= lfsr_next;
                    if (w != 4'd0) begin
                        addr_q  <= address;
                        wdata_q <= writedata;
                        be_q    <= byteenable;
                        rd_q    <= read;
                        wr_q    <= write;
                        cnt     <= w - 4'd1;
                        state   <= WAITING;
                    end
                end
            end else begin
                if (!req) begin
                    state <= IDLE;
                end else if (cnt != 4'd0) begin
                    cnt <= cnt - 4'd1;
                end else begin
                    state <= IDLE;
                end
            end
            if (abort || addr_chg || (done && (!valid || (e_rd && e_wr)))) begin
                err <= 1'b1;
            end
        end
    end

    // Byte-lane write at the completion edge; memory has no reset.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (e_be[i]) mem[idx][8*i +: 8] <= e_wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_mips_bus_ram_wait.sv
// tb/tb_mips_bus_ram_wait.sv - directed self-checking bench for mips_bus_ram_wait
module tb_mips_bus_ram_wait;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] address = 32'h0;
    logic [31:0] writedata = 32'h0;
    logic [3:0]  byteenable = 4'h0;
    logic        rd_s = 1'b0;
    logic        wr_s = 1'b0;
    int          sel = 0;

    logic [3:0]  rd_v;
    logic [3:0]  wr_v;
    logic [3:0]  wq;
    logic [3:0]  errv;
    logic [31:0] rdd [4];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Route the shared bus request to the selected instance only.
    always_comb begin
        rd_v = '0;
        wr_v = '0;
        for (int k = 0; k < 4; k++) begin
            rd_v[k] = rd_s && (sel == k);
            wr_v[k] = wr_s && (sel == k);
        end
    end

    mips_bus_ram_wait #(.DEPTH_WORDS(64), .BASE_ADDR(32'h0000_1000), .WAIT_MODE(0), .MAX_WAIT(0)) u0 (
        .clk(clk), .rst(rst), .address(address), .write(wr_v[0]), .read(rd_v[0]),
        .waitrequest(wq[0]), .writedata(writedata), .byteenable(byteenable),
        .readdata(rdd[0]), .err(errv[0]));

    mips_bus_ram_wait #(.DEPTH_WORDS(64), .BASE_ADDR(32'h0), .WAIT_MODE(0), .MAX_WAIT(3)) u1 (
        .clk(clk), .rst(rst), .address(address), .write(wr_v[1]), .read(rd_v[1]),
        .waitrequest(wq[1]), .writedata(writedata), .byteenable(byteenable),
        .readdata(rdd[1]), .err(errv[1]));

    mips_bus_ram_wait #(.DEPTH_WORDS(64), .BASE_ADDR(32'h0), .WAIT_MODE(1), .MAX_WAIT(7), .LFSR_SEED(8'hA5)) u2 (
        .clk(clk), .rst(rst), .address(address), .write(wr_v[2]), .read(rd_v[2]),
        .waitrequest(wq[2]), .writedata(writedata), .byteenable(byteenable),
        .readdata(rdd[2]), .err(errv[2]));

    mips_bus_ram_wait #(.DEPTH_WORDS(64), .BASE_ADDR(32'h0), .WAIT_MODE(0), .MAX_WAIT(5)) u3 (
        .clk(clk), .rst(rst), .address(address), .write(wr_v[3]), .read(rd_v[3]),
        .waitrequest(wq[3]), .writedata(writedata), .byteenable(byteenable),
        .readdata(rdd[3]), .err(errv[3]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One bus transfer on instance k; returns wait-cycle count and captured readdata.
    task automatic xfer(input int k, input bit wr, input bit rd, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be,
                        output int waits, output logic [31:0] rdata);
        bit ok;
        ok = 1'b0;
        sel = k; address = a; writedata = d; byteenable = be; wr_s = wr; rd_s = rd;
        waits = 0;
        rdata = 32'h0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!wq[k]) begin
                rdata = rdd[k];
                ok = 1'b1;
                break;
            end
            waits++;
        end
        check("xfer_complete", {31'b0, ok}, 32'd1);
        @(posedge clk);
        #1;
        wr_s = 1'b0;
        rd_s = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        // x^8+x^6+x^5+x^4+1, right-shifting Galois form
        return s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
    endfunction

    function automatic logic [31:0] pat(input int j);
        return 32'h1357_0000 | (32'(j) * 32'h0000_0101);
    endfunction

    int          wt;
    logic [31:0] rv;
    logic [7:0]  lm;
    int          w_first [64];

    initial begin
        // Reset state, including outputs while a request is presented during reset.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        sel = 1; address = 32'h0; rd_s = 1'b1;
        #1;
        check("rst_wq_u1", {31'b0, wq[1]}, 32'd0);
        check("rst_rd_u1", rdd[1], 32'h0);
        rd_s = 1'b0;
        check("rst_err", {28'b0, errv}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Zero-wait write then read.
        xfer(0, 1, 0, 32'h1004, 32'hDEADBEEF, 4'hF, wt, rv);
        check("u0_wr_waits", wt, 0);
        xfer(0, 0, 1, 32'h1004, 32'h0, 4'h0, wt, rv);
        check("u0_rd_waits", wt, 0);
        check("u0_rd_data", rv, 32'hDEADBEEF);
        check("u0_err0", {31'b0, errv[0]}, 32'd0);

        // Byte-enabled partial write and no-op write.
        xfer(0, 1, 0, 32'h1020, 32'h11223344, 4'hF, wt, rv);
        xfer(0, 1, 0, 32'h1020, 32'hAABBCCDD, 4'b0101, wt, rv);
        xfer(0, 0, 1, 32'h1020, 32'h0, 4'h0, wt, rv);
        check("u0_be0101", rv, 32'h11BB33DD);
        xfer(0, 1, 0, 32'h1020, 32'hFFFFFFFF, 4'b0000, wt, rv);
        xfer(0, 0, 1, 32'h1020, 32'h0, 4'hF, wt, rv);
        check("u0_be0000", rv, 32'h11BB33DD);
        check("u0_err1", {31'b0, errv[0]}, 32'd0);

        // Fixed three wait states.
        xfer(1, 1, 0, 32'h0, 32'h24020005, 4'hF, wt, rv);
        check("u1_wr_waits", wt, 3);
        xfer(1, 0, 1, 32'h0, 32'h0, 4'h0, wt, rv);
        check("u1_rd_waits", wt, 3);
        check("u1_rd_data", rv, 32'h24020005);
        check("u1_err0", {31'b0, errv[1]}, 32'd0);

        // Range and alignment errors; err is sticky.
        xfer(0, 0, 1, 32'h1100, 32'h0, 4'h0, wt, rv);
        check("u0_oor_data", rv, 32'h0);
        check("u0_oor_err", {31'b0, errv[0]}, 32'd1);
        xfer(1, 0, 1, 32'h2, 32'h0, 4'h0, wt, rv);
        check("u1_unal_data", rv, 32'h0);
        check("u1_unal_err", {31'b0, errv[1]}, 32'd1);
        xfer(0, 0, 1, 32'h1004, 32'h0, 4'h0, wt, rv);
        check("u0_after_err", rv, 32'hDEADBEEF);
        check("u0_err_sticky", {31'b0, errv[0]}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("u1_err_sticky", {31'b0, errv[1]}, 32'd1);

        // Pseudo-random waits: preload 16 words then 64 reads, twice from reset.
        for (int pass = 0; pass < 2; pass++) begin
            pulse_reset();
            lm = 8'hA5;
            for (int j = 0; j < 16; j++) begin
                xfer(2, 1, 0, 32'(j * 4), pat(j), 4'hF, wt, rv);
                check("u2_wr_waits", wt, 32'(lm % 8'd8));
                lm = lfsr_step(lm);
            end
            for (int i = 0; i < 64; i++) begin
                xfer(2, 0, 1, 32'((i % 16) * 4), 32'h0, 4'h0, wt, rv);
                check("u2_rd_data", rv, pat(i % 16));
                check("u2_rd_waits", wt, 32'(lm % 8'd8));
                if (pass == 0) w_first[i] = wt;
                else check("u2_rerun", wt, w_first[i]);
                lm = lfsr_step(lm);
            end
            check("u2_err", {31'b0, errv[2]}, 32'd0);
        end

        // Reset in the middle of a waited write aborts it.
        xfer(3, 1, 0, 32'h10, 32'h55AA55AA, 4'hF, wt, rv);
        check("u3_wr_waits", wt, 5);
        sel = 3; address = 32'h10; writedata = 32'h12345678; byteenable = 4'hF; wr_s = 1'b1;
        @(negedge clk);
        check("u3_wait1", {31'b0, wq[3]}, 32'd1);
        @(negedge clk);
        check("u3_wait2", {31'b0, wq[3]}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("u3_rst_wq", {31'b0, wq[3]}, 32'd0);
        check("u3_rst_rd", rdd[3], 32'h0);
        @(posedge clk);
        #1;
        wr_s = 1'b0;
        rst = 1'b0;
        xfer(3, 0, 1, 32'h10, 32'h0, 4'h0, wt, rv);
        check("u3_old_data", rv, 32'h55AA55AA);
        check("u3_rd_waits", wt, 5);
        check("u3_err", {31'b0, errv[3]}, 32'd0);
        check("err_cleared", {28'b0, errv}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
